// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the byte-serial SRAM bridge.
//   mbb_state_t : bridge sequencer states
//   LANES       : byte lanes per core word
//   LANE_W      : width of a lane index
//   WAIT_W      : width of the strobe wait-state counter
package rv_mem_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } mbb_state_t;

endpackage

// File: rtl/mbb_lane_pick.sv
// Priority picker for the remaining-lane mask: returns the lowest set lane.
//   mask_i : lanes still to be transferred
//   lane_o : index of the lowest set bit (0 when the mask is empty)
//   any_o  : at least one lane remains
module mbb_lane_pick
  import rv_mem_pkg::*;
(
  input  logic [LANES-1:0]  mask_i,
  output logic [LANE_W-1:0] lane_o,
  output logic              any_o
);

  always_comb begin
    lane_o = '0;
    any_o  = |mask_i;
    // Walk downwards so the lowest set bit wins.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        lane_o = LANE_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_byte_bridge.sv
// Memory-side slave of the rv core. A 32-bit request (addr, wdata, byte-lane
// wstrb) is run as byte-serial cycles on an 8-bit asynchronous SRAM, one byte
// per enabled lane in ascending order. Reads assemble the enabled lanes into a
// 32-bit word (disabled lanes read as zero). Completion is a one-cycle
// mem_data_ready pulse.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_read, mem_write        core request (write wins if both set)
//   mem_addr, mem_wdata        byte address / lane-aligned write data
//   mem_wstrb                  enabled lanes, for reads and writes
//   mem_addr_ready             request fields valid this cycle
//   mem_rdata, mem_data_ready  assembled read word / completion pulse
//   sram_addr                  SRAM byte address {word address, lane}
//   sram_dq_o, sram_dq_i       SRAM write / read byte
//   sram_dq_oe                 drive enable for sram_dq_o
//   sram_ce_n/oe_n/we_n        active-low SRAM strobes
module mem_byte_bridge
  import rv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_STATES = 1   // 0..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  input  logic              mem_addr_ready,
  output logic [31:0]       mem_rdata,
  output logic              mem_data_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dq_o,
  input  logic [7:0]        sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  mbb_state_t          state_q, state_d;
  logic [ADDR_W-3:0]   word_addr_q, word_addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [LANES-1:0]    mask_q, mask_d;
  logic                write_q, write_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [LANE_W-1:0]   lane;
  logic                lane_any;
  logic                sram_active;

  // Address bits the bridge never uses: [1:0] are carried by wstrb and the
  // upper bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_W], mem_addr[1:0], lane_any};

  // Current lane is always the lowest bit still set in the remaining mask;
  // HOLD clears that bit, which advances to the next lane.
  mbb_lane_pick u_lane_pick (
    .mask_i (mask_q),
    .lane_o (lane),
    .any_o  (lane_any)
  );

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    write_d     = write_q;
    wait_d      = wait_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (mem_addr_ready && (mem_read || mem_write)) begin
          word_addr_d = mem_addr[ADDR_W-1:2];
          wdata_d     = mem_wdata;
          mask_d      = mem_wstrb;
          write_d     = mem_write;
          // Reads start from zero so disabled lanes return 8'h00.
          if (!mem_write) begin
            rdata_d = '0;
          end
          state_d = (|mem_wstrb) ? SETUP : DONE;
        end
      end
      SETUP: begin
        wait_d  = WAIT_W'(WAIT_STATES);
        state_d = STROBE;
      end
      STROBE: begin
        if (wait_q == '0) begin
          // Capture on the last strobe cycle, while oe_n is still low.
          if (!write_q) begin
            rdata_d[{lane, 3'b000} +: 8] = sram_dq_i;
          end
          state_d = HOLD;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      HOLD: begin
        mask_d  = mask_q & ~(LANES'(1) << lane);
        state_d = (|mask_d) ? SETUP : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      write_q     <= 1'b0;
      wait_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      write_q     <= write_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
    end
  end

  // SRAM pins decode straight from the state register, so an asynchronous
  // reset releases every strobe and the data driver in the same cycle.
  always_comb begin
    sram_active    = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    sram_ce_n      = !sram_active;
    sram_oe_n      = !((state_q == STROBE) && !write_q);
    sram_we_n      = !((state_q == STROBE) && write_q);
    sram_dq_oe     = sram_active && write_q;
    sram_dq_o      = wdata_q[{lane, 3'b000} +: 8];
    sram_addr      = {word_addr_q, lane};
    mem_data_ready = (state_q == DONE);
    mem_rdata      = rdata_q;
  end

endmodule

// File: tb/tb_mem_byte_bridge.sv
module tb_mem_byte_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  addr_ready;

  logic [31:0] rdata [3];
  logic [2:0]  data_ready, ce_n, oe_n, we_n, dq_oe;
  logic [15:0] saddr [3];
  logic [7:0]  dq_o [3];
  logic [7:0]  dq_i [3];

  logic [7:0]  sram [3][65536];
  int          overlap_cnt [3];

  int tests = 0;
  int fails = 0;

  // Per-request observations.
  int          r_lat, r_oe_pulses, r_we_pulses, r_strobe_cyc;
  logic        r_ce_seen, r_dq_oe_seen;
  logic [15:0] r_addr;
  logic [7:0]  r_dq;
  logic [31:0] r_rdata;

  always #5 clk = ~clk;

  // Instance 0: WAIT_STATES=1, instance 1: 0, instance 2: 15.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 1 : ((g == 1) ? 0 : 15);

    mem_byte_bridge #(
      .ADDR_W      (16),
      .WAIT_STATES (WS)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wstrb      (mem_wstrb),
      .mem_addr_ready (addr_ready[g]),
      .mem_rdata      (rdata[g]),
      .mem_data_ready (data_ready[g]),
      .sram_addr      (saddr[g]),
      .sram_dq_o      (dq_o[g]),
      .sram_dq_i      (dq_i[g]),
      .sram_dq_oe     (dq_oe[g]),
      .sram_ce_n      (ce_n[g]),
      .sram_oe_n      (oe_n[g]),
      .sram_we_n      (we_n[g])
    );

    assign dq_i[g] = (!ce_n[g] && !oe_n[g]) ? sram[g][saddr[g]] : 8'hEE;

    always @(posedge clk) begin
      if (!ce_n[g] && !we_n[g] && dq_oe[g]) sram[g][saddr[g]] <= dq_o[g];
    end

    always @(negedge clk) begin
      if (!oe_n[g] && !we_n[g]) overlap_cnt[g]++;
      if (!oe_n[g] && dq_oe[g]) overlap_cnt[g]++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic run_req(input int i, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    logic prev_oe, prev_we;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
    addr_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    addr_ready[i] = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = 32'hDEAD_BEEF; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
    r_lat = -1; r_oe_pulses = 0; r_we_pulses = 0; r_strobe_cyc = 0;
    r_ce_seen = 1'b0; r_dq_oe_seen = 1'b0; r_addr = '0; r_dq = '0; r_rdata = '0;
    prev_oe = 1'b1; prev_we = 1'b1;
    for (int c = 1; c <= 200 && r_lat < 0; c++) begin
      @(negedge clk);
      if (!ce_n[i]) r_ce_seen = 1'b1;
      if (dq_oe[i]) r_dq_oe_seen = 1'b1;
      if (!oe_n[i] || !we_n[i]) r_strobe_cyc++;
      if (!oe_n[i] && prev_oe) r_oe_pulses++;
      if (!we_n[i] && prev_we) r_we_pulses++;
      if (!we_n[i]) r_dq = dq_o[i];
      if (!we_n[i] || !oe_n[i]) r_addr = saddr[i];
      prev_oe = oe_n[i]; prev_we = we_n[i];
      if (data_ready[i]) begin r_lat = c; r_rdata = rdata[i]; end
    end
    if (r_lat < 0) begin
      tests++; fails++;
      $display("FAIL req_timeout inst%0d: no mem_data_ready within 200 cycles", i);
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({data_ready[0], ce_n[0], oe_n[0], we_n[0], dq_oe[0]} !== 5'b01110) begin
      fails++;
      $display("FAIL reset_strobes: got %b expected 01110",
               {data_ready[0], ce_n[0], oe_n[0], we_n[0], dq_oe[0]});
    end
    tests++;
    if (rdata[0] !== 32'h0) begin
      fails++; $display("FAIL reset_rdata: got %h expected 00000000", rdata[0]);
    end
    tests++;
    if ({saddr[0], dq_o[0]} !== 24'h0) begin
      fails++; $display("FAIL reset_addr_dq: got %h expected 000000", {saddr[0], dq_o[0]});
    end
  endtask

  task automatic test_word_read();
    run_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b1111);
    tests++;
    if (r_lat !== 17) begin fails++; $display("FAIL word_read_lat: got %0d expected 17", r_lat); end
    tests++;
    if (r_rdata !== 32'h4433_2211) begin
      fails++; $display("FAIL word_read_data: got %h expected 44332211", r_rdata);
    end
    tests++;
    if ({r_oe_pulses, r_we_pulses, r_strobe_cyc} !== {32'd4, 32'd0, 32'd8}) begin
      fails++;
      $display("FAIL word_read_strobes: got oe=%0d we=%0d cyc=%0d expected 4 0 8",
               r_oe_pulses, r_we_pulses, r_strobe_cyc);
    end
    tests++;
    if (r_dq_oe_seen !== 1'b0) begin fails++; $display("FAIL word_read_dq_oe: got 1 expected 0"); end
    @(negedge clk);
    tests++;
    if ({data_ready[0], rdata[0]} !== {1'b0, 32'h4433_2211}) begin
      fails++;
      $display("FAIL ready_pulse_hold: got rdy=%b data=%h expected 0 44332211",
               data_ready[0], rdata[0]);
    end
  endtask

  task automatic test_byte_write();
    run_req(0, 1'b0, 1'b1, 32'h0000_0202, 32'h00AB_0000, 4'b0100);
    tests++;
    if (r_lat !== 5) begin fails++; $display("FAIL byte_write_lat: got %0d expected 5", r_lat); end
    tests++;
    if ({r_we_pulses, r_oe_pulses} !== {32'd1, 32'd0}) begin
      fails++; $display("FAIL byte_write_pulses: got we=%0d oe=%0d expected 1 0", r_we_pulses,
                        r_oe_pulses);
    end
    tests++;
    if ({r_addr, r_dq} !== {16'h0202, 8'hAB}) begin
      fails++; $display("FAIL byte_write_bus: got addr=%h dq=%h expected 0202 ab", r_addr, r_dq);
    end
    tests++;
    if ({sram[0][16'h0203], sram[0][16'h0202], sram[0][16'h0201], sram[0][16'h0200]}
        !== 32'h00AB_0000) begin
      fails++;
      $display("FAIL byte_write_mem: got %h expected 00ab0000",
               {sram[0][16'h0203], sram[0][16'h0202], sram[0][16'h0201], sram[0][16'h0200]});
    end
  endtask

  task automatic test_half_read();
    run_req(0, 1'b1, 1'b0, 32'h0000_0006, 32'h0, 4'b1100);
    tests++;
    if (r_rdata !== 32'hDDCC_0000) begin
      fails++; $display("FAIL half_read_data: got %h expected ddcc0000", r_rdata);
    end
    tests++;
    if ({r_oe_pulses, r_lat} !== {32'd2, 32'd9}) begin
      fails++; $display("FAIL half_read_timing: got oe=%0d lat=%0d expected 2 9", r_oe_pulses, r_lat);
    end
    tests++;
    if (r_addr !== 16'h0007) begin
      fails++; $display("FAIL half_read_last_addr: got %h expected 0007", r_addr);
    end
  endtask

  task automatic test_zero_strobe();
    run_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b0000);
    tests++;
    if ({r_lat, r_ce_seen} !== {32'd1, 1'b0}) begin
      fails++; $display("FAIL zero_strb: got lat=%0d ce_seen=%b expected 1 0", r_lat, r_ce_seen);
    end
    tests++;
    if (r_rdata !== 32'h0) begin fails++; $display("FAIL zero_strb_rdata: got %h expected 0", r_rdata); end
    run_req(0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_005A, 4'b0001);
    tests++;
    if ({r_we_pulses, r_oe_pulses, sram[0][16'h0300]} !== {32'd1, 32'd0, 8'h5A}) begin
      fails++;
      $display("FAIL rd_wr_both: got we=%0d oe=%0d mem=%h expected 1 0 5a", r_we_pulses,
               r_oe_pulses, sram[0][16'h0300]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pulses;
    int extra;
    pulses = '0; extra = 0;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; mem_addr = 32'h0000_0100; mem_wstrb = 4'b0001;
    addr_ready[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (data_ready[0]) pulses[c] = 1'b1;
      if (c == 11) begin addr_ready[0] = 1'b0; mem_read = 1'b0; end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (data_ready[0]) extra++;
    end
    tests++;
    if (pulses !== 16'h0820) begin
      fails++; $display("FAIL back_to_back: got pulse map %h expected 0820", pulses);
    end
    tests++;
    if (extra !== 0) begin fails++; $display("FAIL back_to_back_stop: got %0d extra expected 0", extra); end
  endtask

  task automatic test_reset_midstrobe();
    logic we_low;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; mem_addr = 32'h0000_0400; mem_wdata = 32'h8765_4321;
    mem_wstrb = 4'b1111; addr_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    addr_ready[0] = 1'b0; mem_write = 1'b0;
    we_low = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) we_low = !we_n[0] && (saddr[0] === 16'h0401);
    end
    tests++;
    if (we_low !== 1'b1) begin fails++; $display("FAIL midstrobe_setup: got we_low=0 expected 1"); end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ce_n[0], oe_n[0], we_n[0], dq_oe[0], data_ready[0]} !== 5'b11100) begin
      fails++;
      $display("FAIL midstrobe_reset: got %b expected 11100",
               {ce_n[0], oe_n[0], we_n[0], dq_oe[0], data_ready[0]});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (sram[0][16'h0400] !== 8'h21) begin
      fails++; $display("FAIL midstrobe_lane0: got %h expected 21", sram[0][16'h0400]);
    end
    run_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b1111);
    tests++;
    if ({r_lat, r_rdata} !== {32'd17, 32'h4433_2211}) begin
      fails++;
      $display("FAIL after_reset_read: got lat=%0d data=%h expected 17 44332211", r_lat, r_rdata);
    end
  endtask

  task automatic test_wait_sweep();
    run_req(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b1111);
    tests++;
    if ({r_lat, r_strobe_cyc, r_oe_pulses, r_rdata} !== {32'd13, 32'd4, 32'd4, 32'h4433_2211}) begin
      fails++;
      $display("FAIL ws0_read: got lat=%0d cyc=%0d oe=%0d data=%h expected 13 4 4 44332211",
               r_lat, r_strobe_cyc, r_oe_pulses, r_rdata);
    end
    run_req(2, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b0010);
    tests++;
    if ({r_lat, r_strobe_cyc, r_oe_pulses, r_rdata} !== {32'd19, 32'd16, 32'd1, 32'h0000_2200}) begin
      fails++;
      $display("FAIL ws15_read: got lat=%0d cyc=%0d oe=%0d data=%h expected 19 16 1 00002200",
               r_lat, r_strobe_cyc, r_oe_pulses, r_rdata);
    end
    run_req(2, 1'b0, 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 4'b1111);
    tests++;
    if ({r_lat, r_strobe_cyc, r_we_pulses} !== {32'd73, 32'd64, 32'd4}) begin
      fails++;
      $display("FAIL ws15_write: got lat=%0d cyc=%0d we=%0d expected 73 64 4", r_lat,
               r_strobe_cyc, r_we_pulses);
    end
    tests++;
    if ({sram[2][16'h0503], sram[2][16'h0502], sram[2][16'h0501], sram[2][16'h0500]}
        !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL ws15_write_mem: got %h expected cafef00d",
               {sram[2][16'h0503], sram[2][16'h0502], sram[2][16'h0501], sram[2][16'h0500]});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    addr_ready = '0;
    for (int g = 0; g < 3; g++) begin
      overlap_cnt[g] = 0;
      sram[g][16'h0100] = 8'h11; sram[g][16'h0101] = 8'h22;
      sram[g][16'h0102] = 8'h33; sram[g][16'h0103] = 8'h44;
      sram[g][16'h0004] = 8'hAA; sram[g][16'h0005] = 8'hBB;
      sram[g][16'h0006] = 8'hCC; sram[g][16'h0007] = 8'hDD;
      for (int a = 16'h0200; a <= 16'h0203; a++) sram[g][a] = 8'h00;
      sram[g][16'h0300] = 8'h00;
    end
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_word_read();
    test_byte_write();
    test_half_read();
    test_zero_strobe();
    test_back_to_back();
    test_reset_midstrobe();
    test_wait_sweep();
    tests++;
    if (overlap_cnt[0] + overlap_cnt[1] + overlap_cnt[2] !== 0) begin
      fails++;
      $display("FAIL strobe_overlap: got %0d cycles expected 0",
               overlap_cnt[0] + overlap_cnt[1] + overlap_cnt[2]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
